// File: rtl/muldiv_unit_if.sv
// Issue/result bus between the EX-stage pipeline and the HI/LO multiply/divide unit.
interface muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              op_valid;
  logic [7:0]        md_op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              op_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output op_valid, md_op, src_a, src_b, flush,
    input  op_ready, rd_data, rd_valid, busy, hi_o, lo_o
  );

  modport slave (
    input  op_valid, md_op, src_a, src_b, flush,
    output op_ready, rd_data, rd_valid, busy, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply, restoring divide
// (one quotient bit per cycle), mfhi/mflo/mthi/mtlo and flush support.
module muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input logic          clk,
  input logic          resetn,
  muldiv_unit_if.slave md
);
  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi_q, lo_q;

  // Operand / iteration registers; only meaningful while state says so.
  logic [DATA_W-1:0] opa_p0, opb_p0, rem_p0, quo_p0;
  logic              mul_sgn_p0, q_neg_p0, r_neg_p0;

  logic op_div, op_divu, op_mult, op_multu, op_mfhi, op_mflo, op_mthi, op_mtlo;
  logic idle, accept;
  logic [2*DATA_W-1:0] prod, step;
  logic [DATA_W-1:0]   step_rem, step_quo, div_lo, div_hi;

  function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic sgn);
    logic signed [2*DATA_W-1:0] ea, eb;
    ea = $signed({{DATA_W{sgn & a[DATA_W-1]}}, a});
    eb = $signed({{DATA_W{sgn & b[DATA_W-1]}}, b});
    return $unsigned(ea * eb);
  endfunction

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  // One restoring step: returns {remainder, quotient-shift-register}.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                   input logic [DATA_W-1:0] quo,
                                                   input logic [DATA_W-1:0] dvs);
    logic [DATA_W:0] sh, diff;
    sh   = {rem, quo[DATA_W-1]};
    diff = sh - {1'b0, dvs};
    if (diff[DATA_W]) return {sh[DATA_W-1:0], quo[DATA_W-2:0], 1'b0};
    else              return {diff[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
  endfunction

  assign {op_div, op_divu, op_mult, op_multu, op_mfhi, op_mflo, op_mthi, op_mtlo} = md.md_op;

  // Multi-hot md_op is never accepted; op_ready depends on state alone.
  assign idle   = (state == S_IDLE);
  assign accept = md.op_valid & idle & ~md.flush & $onehot(md.md_op);

  assign md.op_ready = idle;
  assign md.busy     = ~idle;
  assign md.rd_valid = accept & (op_mfhi | op_mflo);
  assign md.rd_data  = (accept & op_mfhi) ? hi_q :
                       (accept & op_mflo) ? lo_q : '0;
  assign md.hi_o     = hi_q;
  assign md.lo_o     = lo_q;

  // Product, next divide step and sign-fixed divide result (zero divisor special-cased).
  always_comb begin
    prod     = mul_full(opa_p0, opb_p0, mul_sgn_p0);
    step     = div_step(rem_p0, quo_p0, opb_p0);
    step_rem = step[2*DATA_W-1:DATA_W];
    step_quo = step[DATA_W-1:0];
    div_lo   = (opb_p0 == '0) ? '1     : cond_neg(step_quo, q_neg_p0);
    div_hi   = (opb_p0 == '0) ? opa_p0 : cond_neg(step_rem, r_neg_p0);
  end

  // Control FSM and architectural HI/LO; flush cancels any pending write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            if (op_mthi) hi_q <= md.src_a;
            if (op_mtlo) lo_q <= md.src_a;
            if (op_mult | op_multu) state <= S_MUL;
            if (op_div | op_divu)   state <= S_DIV;
          end
        end
        S_MUL: begin
          if (md.flush) begin
            state <= S_IDLE;
          end else if (cnt == MUL_LAST) begin
            {hi_q, lo_q} <= prod;
            state        <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (md.flush) begin
            state <= S_IDLE;
          end else if (cnt == DIV_LAST) begin
            hi_q  <= div_hi;
            lo_q  <= div_lo;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture at acceptance, then one restoring iteration per DIV cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa_p0     <= md.src_a;
      opb_p0     <= abs_val(md.src_b, op_div);
      quo_p0     <= abs_val(md.src_a, op_div);
      rem_p0     <= '0;
      mul_sgn_p0 <= op_mult;
      q_neg_p0   <= op_div & (md.src_a[DATA_W-1] ^ md.src_b[DATA_W-1]);
      r_neg_p0   <= op_div & md.src_a[DATA_W-1];
    end else if (state == S_DIV) begin
      rem_p0 <= step_rem;
      quo_p0 <= step_quo;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// flush/hazard/reset sequences and randomized ops against a reference model.
module tb_muldiv_unit;
  localparam int DATA_W  = 32;
  localparam int MUL_LAT = 2;

  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_DIVU  = 8'h40;
  localparam logic [7:0] OP_MULT  = 8'h20;
  localparam logic [7:0] OP_MULTU = 8'h10;
  localparam logic [7:0] OP_MFHI  = 8'h08;
  localparam logic [7:0] OP_MFLO  = 8'h04;
  localparam logic [7:0] OP_MTHI  = 8'h02;
  localparam logic [7:0] OP_MTLO  = 8'h01;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;
  logic [31:0] mhi;
  logic [31:0] mlo;
  vec_t vecs[13];
  logic [7:0] ops[8];

  muldiv_unit_if #(.DATA_W(DATA_W)) bus();

  muldiv_unit #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural effect of one op from plain arithmetic.
  task automatic model_apply(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rd, output int lat);
    longint      sq, sr;
    logic [63:0] p;
    rd  = 32'h0;
    lat = 0;
    case (op)
      OP_MTHI: mhi = a;
      OP_MTLO: mlo = a;
      OP_MFHI: rd = mhi;
      OP_MFLO: rd = mlo;
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {mhi, mlo} = p;
        lat = MUL_LAT;
      end
      OP_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        {mhi, mlo} = p;
        lat = MUL_LAT;
      end
      OP_DIV, OP_DIVU: begin
        lat = DATA_W;
        if (b == 32'h0) begin
          mlo = 32'hFFFF_FFFF;
          mhi = a;
        end else if (op == OP_DIV) begin
          sq  = longint'($signed(a)) / longint'($signed(b));
          sr  = longint'($signed(a)) % longint'($signed(b));
          mlo = sq[31:0];
          mhi = sr[31:0];
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one op from IDLE and follow it to completion (bounded wait).
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rd, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat, input string nm);
    int n, nr;
    bus.op_valid = 1'b1;
    bus.md_op    = op;
    bus.src_a    = a;
    bus.src_b    = b;
    #1;
    chk({nm, "_ready"}, bus.op_ready, 1);
    chk({nm, "_rdvalid"}, bus.rd_valid, (op == OP_MFHI || op == OP_MFLO));
    chk({nm, "_rddata"}, bus.rd_data, rd);
    tick();
    bus.op_valid = 1'b0;
    bus.md_op    = 8'h0;
    n  = 0;
    nr = 0;
    while (bus.busy && n < 100) begin
      if (!bus.op_ready) nr++;
      tick();
      n++;
    end
    chk({nm, "_busycycles"}, n, lat);
    chk({nm, "_stallcycles"}, nr, lat);
    chk({nm, "_hi"}, bus.hi_o, ehi);
    chk({nm, "_lo"}, bus.lo_o, elo);
  endtask

  initial begin
    logic [31:0] rdx;
    int          latx, n;
    n_cmp = 0;
    n_bad = 0;
    mhi = 32'h0;
    mlo = 32'h0;
    ops = '{OP_DIV, OP_DIVU, OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};

    vecs[0]  = '{OP_MTHI,  32'h12345678, 32'h0,        32'h0,        32'h12345678, 32'h0,        0};
    vecs[1]  = '{OP_MTLO,  32'h9ABCDEF0, 32'h0,        32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
    vecs[2]  = '{OP_MFHI,  32'h0,        32'h0,        32'h12345678, 32'h12345678, 32'h9ABCDEF0, 0};
    vecs[3]  = '{OP_MFLO,  32'h0,        32'h0,        32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 0};
    vecs[4]  = '{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 2};
    vecs[5]  = '{OP_MULTU, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h00000002, 32'hFFFFFFFA, 2};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 32};
    vecs[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'h0,        32'h00000002, 32'h0000000E, 32};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'h80000000, 32};
    vecs[9]  = '{OP_DIVU,  32'd5,        32'h0,        32'h0,        32'h00000005, 32'hFFFFFFFF, 32};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'h0,        32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 32};
    vecs[11] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,        32'h00000001, 32'hFFFFFFFD, 32};
    vecs[12] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFE, 32'h00000001, 2};

    resetn       = 1'b0;
    bus.op_valid = 1'b0;
    bus.md_op    = 8'h0;
    bus.src_a    = 32'h0;
    bus.src_b    = 32'h0;
    bus.flush    = 1'b0;
    repeat (3) tick();
    chk("reset_hi", bus.hi_o, 0);
    chk("reset_lo", bus.lo_o, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rdvalid", bus.rd_valid, 0);
    chk("reset_rddata", bus.rd_data, 0);
    chk("reset_ready", bus.op_ready, 1);
    resetn = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].hi, vecs[i].lo,
             vecs[i].lat, $sformatf("vec%0d", i));
      model_apply(vecs[i].op, vecs[i].a, vecs[i].b, rdx, latx);
    end

    // mfhi presented during a divide stalls, then reads the new HI
    bus.op_valid = 1'b1;
    bus.md_op    = OP_DIVU;
    bus.src_a    = 32'd100;
    bus.src_b    = 32'd7;
    tick();
    model_apply(OP_DIVU, 32'd100, 32'd7, rdx, latx);
    bus.md_op = OP_MFHI;
    n = 0;
    while (!bus.op_ready && n < 100) begin
      chk("hazard_rdvalid_stalled", bus.rd_valid, 0);
      tick();
      n++;
    end
    chk("hazard_stall_cycles", n, 32);
    chk("hazard_rdvalid", bus.rd_valid, 1);
    chk("hazard_rddata", bus.rd_data, mhi);
    tick();
    bus.op_valid = 1'b0;
    bus.md_op    = 8'h0;

    // flush at iteration 10 of a divide
    model_apply(OP_MTHI, 32'hAAAA5555, 32'h0, rdx, latx);
    run_op(OP_MTHI, 32'hAAAA5555, 32'h0, 32'h0, mhi, mlo, 0, "pre_flush_mthi");
    model_apply(OP_MTLO, 32'h5555AAAA, 32'h0, rdx, latx);
    run_op(OP_MTLO, 32'h5555AAAA, 32'h0, 32'h0, mhi, mlo, 0, "pre_flush_mtlo");
    bus.op_valid = 1'b1;
    bus.md_op    = OP_DIV;
    bus.src_a    = 32'd100;
    bus.src_b    = 32'd7;
    tick();
    bus.op_valid = 1'b0;
    bus.md_op    = 8'h0;
    repeat (9) tick();
    chk("flush_div_busy_before", bus.busy, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_div_busy_after", bus.busy, 0);
    chk("flush_div_hi", bus.hi_o, mhi);
    chk("flush_div_lo", bus.lo_o, mlo);
    run_op(OP_MFLO, 32'h0, 32'h0, mlo, mhi, mlo, 0, "after_flush_mflo");

    // flush on the multiply completion edge wins
    bus.op_valid = 1'b1;
    bus.md_op    = OP_MULT;
    bus.src_a    = 32'd3;
    bus.src_b    = 32'd5;
    tick();
    bus.op_valid = 1'b0;
    bus.md_op    = 8'h0;
    tick();
    chk("flush_mul_busy_before", bus.busy, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_mul_busy_after", bus.busy, 0);
    chk("flush_mul_hi", bus.hi_o, mhi);
    chk("flush_mul_lo", bus.lo_o, mlo);

    // flush in IDLE blocks acceptance
    bus.op_valid = 1'b1;
    bus.md_op    = OP_MFHI;
    bus.flush    = 1'b1;
    #1;
    chk("flush_idle_rdvalid", bus.rd_valid, 0);
    chk("flush_idle_rddata", bus.rd_data, 0);
    bus.md_op = OP_MTHI;
    bus.src_a = 32'hDEADBEEF;
    tick();
    chk("flush_idle_hi", bus.hi_o, mhi);
    bus.md_op = OP_DIV;
    tick();
    chk("flush_idle_busy", bus.busy, 0);
    bus.flush    = 1'b0;
    bus.op_valid = 1'b0;
    bus.md_op    = 8'h0;

    // multi-hot md_op is ignored
    bus.op_valid = 1'b1;
    bus.md_op    = 8'h03;
    bus.src_a    = 32'h00000077;
    #1;
    chk("illegal_ready", bus.op_ready, 1);
    chk("illegal_rdvalid", bus.rd_valid, 0);
    tick();
    chk("illegal_hi", bus.hi_o, mhi);
    chk("illegal_lo", bus.lo_o, mlo);
    bus.md_op = 8'h88;
    #1;
    chk("illegal2_rdvalid", bus.rd_valid, 0);
    tick();
    chk("illegal2_busy", bus.busy, 0);
    bus.op_valid = 1'b0;
    bus.md_op    = 8'h0;

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b, rd;
      int          lat;
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      model_apply(op, a, b, rd, lat);
      run_op(op, a, b, rd, mhi, mlo, lat, $sformatf("rnd%0d", i));
    end

    // reset in the middle of a multiply
    bus.op_valid = 1'b1;
    bus.md_op    = OP_MULT;
    bus.src_a    = 32'h7;
    bus.src_b    = 32'h9;
    tick();
    bus.op_valid = 1'b0;
    bus.md_op    = 8'h0;
    chk("rst_mul_busy_before", bus.busy, 1);
    resetn = 1'b0;
    tick();
    chk("rst_mul_hi", bus.hi_o, 0);
    chk("rst_mul_lo", bus.lo_o, 0);
    chk("rst_mul_busy", bus.busy, 0);
    resetn = 1'b1;
    mhi = 32'h0;
    mlo = 32'h0;
    tick();
    repeat (2) tick();
    chk("rst_mul_hi_later", bus.hi_o, 0);
    run_op(OP_MFHI, 32'h0, 32'h0, mhi, mhi, mlo, 0, "post_reset_mfhi");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit driven by the decoder's 8-bit one-hot MD op vector {div, divu, mult, multu, mfhi, mflo, mthi, mtlo}.
- Sits in the EX stage beside the ALU and owns the architectural HI/LO registers.
- Multiply has a parametrised latency; division is iterative restoring, one quotient bit per cycle.
- Handshake and flush let the pipeline stall on HI/LO hazards and cancel in-flight ops on exceptions.

Parameters:
- DATA_W, 32, operand/HI/LO width (>=4).
- MUL_LAT, 2, cycles from multiply acceptance to HI/LO update (>=1).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- op_valid  in  1  md_op/operands valid this cycle.
- md_op  in  8  one-hot {div,divu,mult,multu,mfhi,mflo,mthi,mtlo}; all-zero = no op.
- src_a  in  DATA_W  rs value (dividend / multiplicand / mthi-mtlo data).
- src_b  in  DATA_W  rt value (divisor / multiplier).
- flush  in  1  cancel in-flight and presented op.
- op_ready  out  1  op accepted when op_valid & op_ready & ~flush.
- rd_data  out  DATA_W  HI (mfhi) or LO (mflo) on acceptance cycle, else 0.
- rd_valid  out  1  high on the cycle a mfhi/mflo is accepted.
- busy  out  1  high while state != IDLE.
- hi_o  out  DATA_W  current HI register.
- lo_o  out  DATA_W  current LO register.

Behaviour:
- Reset (resetn=0 at an edge):
  - state=IDLE, HI=LO=0, counter=0.
  - busy=0, rd_valid=0, rd_data=0.
  - Any in-flight op is discarded. Reset overrides flush and op_valid.
- States:
  - IDLE: mult/multu accepted -> MUL; div/divu accepted -> DIV.
  - MUL: count MUL_LAT cycles -> IDLE.
  - DIV: DATA_W iterations -> IDLE.
- op_ready:
  - IDLE: 1.
  - MUL/DIV: 0 for every md_op (structural/HI-LO hazard stalls upstream).
- mthi/mtlo (IDLE only): HI or LO = src_a at the accepting edge. The other register is unchanged.
- mfhi/mflo (IDLE only): rd_data = HI/LO combinationally, rd_valid=1, same cycle; no state change.
- Multiply:
  - Operands captured at acceptance edge E.
  - {HI,LO} = 2*DATA_W-bit product (signed for mult, unsigned for multu) written at edge E+MUL_LAT; state returns to IDLE at that same edge.
  - busy=1 for exactly MUL_LAT cycles.
- Divide:
  - At E: capture |a|, |b| (raw values for divu) and the quotient/remainder signs.
  - Edges E+1..E+DATA_W: one restoring step each.
  - At E+DATA_W, apply sign fix and write LO=quotient, HI=remainder; state returns to IDLE.
  - busy=1 for DATA_W cycles.
- Divide arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - divisor=0: LO = all ones, HI = src_a, same latency.
  - Signed INT_MIN / -1: LO = INT_MIN, HI = 0.
- flush:
  - In MUL/DIV: next state IDLE, HI/LO unchanged, no write.
  - In IDLE with op_valid: op not accepted; no HI/LO write, rd_valid=0.
  - A new op can be accepted on the cycle after a flush.
- Simultaneous events:
  - The completion edge and flush in the same cycle: flush wins, no write.
  - The completion edge sets state=IDLE, so op_ready=1 in the following cycle. A dependent mfhi there reads the new value.
- md_op with more than one bit set: illegal. It is not accepted and op_ready is unaffected.

Test Plan:
- Reset then mthi 0x12345678, mtlo 0x9ABCDEF0, then mfhi / mflo -> rd_data 0x12345678 / 0x9ABCDEF0, rd_valid=1, busy=0.
- mult 0xFFFFFFFE x 3 (MUL_LAT=2) -> busy 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div -7 / 2 -> op_ready=0 for 32 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 -> LO=14, HI=2.
- Edge cases:
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu 5 / 0 -> LO=0xFFFFFFFF, HI=5.
- mfhi presented during a divide -> op_ready=0 until completion; accepted the cycle after, returns the new HI.
- Flush and reset mid-op:
  - flush at iteration 10 of a div -> HI/LO keep prior values, busy=0 next cycle.
  - resetn=0 mid-mult -> HI=LO=0, busy=0.
